bt656_capture_ctrl: RTL and testbench
=====================================

// Module: bt656_capture_ctrl
// PURPOSE
//  Frame-capture controller behind the BT.656 source. Parses the 8-bit byte stream for
//  timing reference codes (FF 00 00 XY), checks protection bits and tracks F/V/H.
//  Gates active-video bytes of one or more whole interlaced frames (field 0 + field 1)
//  into a small FIFO and presents them downstream with SOF/EOL framing.
//  Start/stop/mode come from the control register block; status and errors go back to it.
// PARAMETERS
//  FIFO_DEPTH  16  output FIFO entries (power of 2, >=4)
//  CNT_W       16  width of status counters
// PORTS
//  ACLK               in   1      clock
//  ARESETn            in   1      asynchronous reset, active low
//  in_valid_i         in   1      in_data_i valid this cycle (no backpressure on input)
//  in_data_i          in   8      BT.656 byte
//  ctrl_start_i       in   1      one-cycle pulse: arm capture
//  ctrl_stop_i        in   1      one-cycle pulse: stop at next frame boundary
//  ctrl_continuous_i  in   1      1 = capture frames until stopped, 0 = single frame
//  err_clr_i          in   1      one-cycle pulse: clear sticky errors
//  out_valid_o        out  1      output byte valid
//  out_ready_i        in   1      downstream accepts byte
//  out_data_o         out  8      active-video byte
//  out_sof_o          out  1      first byte of frame (qualified by out_valid_o)
//  out_eol_o          out  1      last byte of active line (qualified by out_valid_o)
//  status_busy_o      out  1      capture state != C_OFF
//  status_frame_cnt_o out  CNT_W  completed frames since reset, wraps
//  status_line_len_o  out  CNT_W  byte count of last captured active line
//  status_lines_o     out  CNT_W  active lines in last completed frame
//  err_hdr_o          out  1      sticky: XY bit7=0 or protection-bit mismatch
//  err_ovf_o          out  1      sticky: FIFO full on write, byte dropped
// BEHAVIOUR
//  - Reset: all outputs 0, FSMs in idle, FIFO empty, counters 0. Async reset mid-frame
//    discards FIFO contents; no partial EOL is emitted.
//  - Parser (advances only on in_valid_i): P_IDLE -FF-> P_FF -00-> P_Z1 -00-> P_Z2 -any-> P_IDLE.
//    Mismatch returns to P_IDLE (FF re-enters P_FF). XY = {1,F,V,H,V^H,F^H,F^V,F^V^H}.
//    Valid XY updates F/V/H and emits hdr_strobe; invalid sets err_hdr_o, state unchanged.
//  - Active byte: in_valid_i, parser in P_IDLE, last valid header H=0 (SAV), V=0, and not FF.
//  - Capture FSM: C_OFF -start-> C_ARMED -> C_ACTIVE -> C_OFF/C_ARMED.
//    C_ARMED: wait for SAV with F=0,V=0 whose previous valid header had V=1 -> C_ACTIVE.
//    C_ACTIVE: forward active bytes. Frame done = first valid header F=1,V=1 after at least
//    one F=1,V=0 line captured. On done: frame_cnt++, lines latched; then C_OFF if
//    continuous=0 or stop pending, else C_ARMED.
//  - ctrl_stop_i in C_ARMED -> C_OFF next cycle; in C_ACTIVE sets stop_pend (frame finishes).
//    ctrl_start_i ignored unless C_OFF. Start and stop in same cycle: stop wins.
//  - One-byte hold register: each active byte is held until the next active byte (written
//    eol=0) or FF of the EAV (written eol=1). sof=1 on the first byte written in a frame.
//  - Latency: byte N appears at FIFO output 2 cycles after byte N+1 (or EAV FF) is accepted.
//  - FIFO write when full: byte dropped, err_ovf_o=1; if dropped byte had eol, eol is lost.
//  - out_* follow valid/ready: held stable while out_valid_o & !out_ready_i.
//  - line_len counts bytes per line, latched at EAV of each captured line; saturates at max.
//  - err_clr_i clears both sticky errors; a same-cycle new error wins (stays set).
// STRUCTURE
//  bt656_pkg: TRS byte constants, trs_hdr_t {f,v,h}, parser/capture state enums,
//  function xy_valid(byte) for protection check.
//  Sub-module bt656_cap_fifo: sync FIFO of {sof,eol,data[7:0]}, FIFO_DEPTH entries.
// TESTING
//  - Generator 24 px/line (48 B), 32 lines, pure BT.656, single mode, start -> exactly
//    16 lines x 48 B; eol on bytes 48,96,..; one sof; frame_cnt=1; lines=16; line_len=48.
//  - Continuous mode, 3 frames then stop mid-frame 3 -> frame 3 completes, busy drops,
//    frame_cnt=3, no bytes captured afterwards.
//  - Start issued mid-field 1 -> no output until next field-0 first active line; first
//    byte has sof=1 and equals {line 5 [3:0], 0}.
//  - Corrupt one SAV XY (flip P0) -> err_hdr_o=1, header ignored; err_clr_i -> 0.
//  - out_ready_i held 0 for 40 cycles during active line -> err_ovf_o=1, output stable
//    while stalled, subsequent lines intact.
//  - ARESETn pulsed mid-line -> all outputs 0 immediately; next start captures a clean frame.

Source files
------------

// File: rtl/bt656_pkg.sv
// Shared types for the BT.656 capture controller: TRS constants, header fields, FSM states.
// The protection check rebuilds P3..P0 from F/V/H and compares them with the received XY.
package bt656_pkg;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    typedef struct packed {
        logic f;
        logic v;
        logic h;
    } trs_hdr_t;

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic [7:0] dat;
    } cap_word_t;

    typedef enum logic [1:0] {P_IDLE, P_FF, P_Z1, P_Z2} parse_state_t;
    typedef enum logic [1:0] {C_OFF, C_ARMED, C_ACTIVE} cap_state_t;

    function automatic logic xy_valid(input logic [7:0] xy);
        logic f, v, h;
        f = xy[6];
        v = xy[5];
        h = xy[4];
        return xy[7] && (xy[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
    endfunction

endpackage

// File: rtl/bt656_capture_ctrl_if.sv
// Valid/ready stream of captured words {sof, eol, data}.
// Producer holds vld/dat stable until rdy is seen.
interface bt656_capture_ctrl_if;
    import bt656_pkg::*;

    logic      vld;
    logic      rdy;
    cap_word_t dat;

    modport master (output vld, output dat, input rdy);
    modport slave  (input vld, input dat, output rdy);
endinterface

// File: rtl/bt656_cap_fifo.sv
// Synchronous FIFO of captured words; writes into a full FIFO are dropped.
// Latency: a written word is visible on rd the cycle after the write.
// Backpressure: rd.rdy low holds the head word; no backpressure on the write side.
module bt656_cap_fifo
    import bt656_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 wr_vld,
    input  cap_word_t            wr_dat,
    output logic                 full,
    bt656_capture_ctrl_if.master rd
);
    localparam int AW = $clog2(DEPTH);

    cap_word_t   mem [DEPTH];
    logic [AW:0] wptr, rptr;

    // Extra pointer MSB separates full from empty when the indices match.
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd.vld = (wptr != rptr);
    assign rd.dat = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_vld && !full) wptr <= wptr + 1'b1;
            if (rd.vld && rd.rdy) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld && !full) mem[wptr[AW-1:0]] <= wr_dat;
    end
endmodule

// File: rtl/bt656_capture_ctrl.sv
// BT.656 frame capture: TRS parsing, whole-frame gating, SOF/EOL framing into an output FIFO.
// Latency: a byte reaches the FIFO output 2 cycles after the following byte (or EAV FF).
// Backpressure: out_ready_i stalls the FIFO only; input never stalls, overflow drops bytes.
module bt656_capture_ctrl
    import bt656_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    input  logic             ctrl_start_i,
    input  logic             ctrl_stop_i,
    input  logic             ctrl_continuous_i,
    input  logic             err_clr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [7:0]       out_data_o,
    output logic             out_sof_o,
    output logic             out_eol_o,
    output logic             status_busy_o,
    output logic [CNT_W-1:0] status_frame_cnt_o,
    output logic [CNT_W-1:0] status_line_len_o,
    output logic [CNT_W-1:0] status_lines_o,
    output logic             err_hdr_o,
    output logic             err_ovf_o
);
    parse_state_t     p_q, p_d;
    cap_state_t       c_q, c_d;
    trs_hdr_t         hdr_q, new_hdr;
    logic             hdr_seen, hdr_ok, hdr_strobe, hdr_err;
    logic             ff_idle, act_byte, cap_byte, eol_evt, enter_active, frame_done;
    logic             stop_pend_q, f1_seen_q, sof_pend_q;
    logic             hold_vld_q, hold_sof_q;
    logic [7:0]       hold_dat_q;
    logic             wr_vld_q, fifo_full;
    cap_word_t        wr_dat_q;
    logic [CNT_W-1:0] line_cnt_q, lines_acc_q, frame_cnt_q, line_len_q, lines_q;
    logic             err_hdr_q, err_ovf_q;

    bt656_capture_ctrl_if out_if ();

    assign new_hdr    = trs_hdr_t'(in_data_i[6:4]);
    assign hdr_strobe = hdr_seen && hdr_ok;
    assign hdr_err    = hdr_seen && !hdr_ok;
    assign ff_idle    = in_valid_i && (p_q == P_IDLE) && (in_data_i == TRS_FF);
    assign act_byte   = in_valid_i && (p_q == P_IDLE) && !hdr_q.h && !hdr_q.v && (in_data_i != TRS_FF);
    assign cap_byte   = act_byte && (c_q == C_ACTIVE);
    // The EAV FF closes a captured line exactly when a byte is still held.
    assign eol_evt    = ff_idle && hold_vld_q;

    always_comb begin
        p_d      = p_q;
        hdr_seen = 1'b0;
        hdr_ok   = 1'b0;
        if (in_valid_i) begin
            unique case (p_q)
                P_IDLE:  if (in_data_i == TRS_FF) p_d = P_FF;
                P_FF:    p_d = (in_data_i == TRS_00) ? P_Z1 : (in_data_i == TRS_FF) ? P_FF : P_IDLE;
                P_Z1:    p_d = (in_data_i == TRS_00) ? P_Z2 : (in_data_i == TRS_FF) ? P_FF : P_IDLE;
                P_Z2: begin
                    p_d      = P_IDLE;
                    hdr_seen = 1'b1;
                    hdr_ok   = xy_valid(in_data_i);
                end
                default: p_d = P_IDLE;
            endcase
        end
    end

    always_comb begin
        c_d          = c_q;
        enter_active = 1'b0;
        frame_done   = 1'b0;
        unique case (c_q)
            C_OFF:    if (ctrl_start_i && !ctrl_stop_i) c_d = C_ARMED;
            C_ARMED: begin
                if (ctrl_stop_i) begin
                    c_d = C_OFF;
                end else if (hdr_strobe && (new_hdr == '0) && hdr_q.v) begin
                    c_d          = C_ACTIVE;
                    enter_active = 1'b1;
                end
            end
            C_ACTIVE: begin
                if (hdr_strobe && new_hdr.f && new_hdr.v && f1_seen_q) begin
                    frame_done = 1'b1;
                    c_d = (!ctrl_continuous_i || stop_pend_q || ctrl_stop_i) ? C_OFF : C_ARMED;
                end
            end
            default:  c_d = C_OFF;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            p_q <= P_IDLE;
            c_q <= C_OFF;
        end else begin
            p_q <= p_d;
            c_q <= c_d;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            hdr_q       <= '0;
            stop_pend_q <= 1'b0;
            f1_seen_q   <= 1'b0;
            sof_pend_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_sof_q  <= 1'b0;
            hold_dat_q  <= '0;
            wr_vld_q    <= 1'b0;
            wr_dat_q    <= '0;
            line_cnt_q  <= '0;
            lines_acc_q <= '0;
            frame_cnt_q <= '0;
            line_len_q  <= '0;
            lines_q     <= '0;
            err_hdr_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            if (hdr_strobe) hdr_q <= new_hdr;
            stop_pend_q <= (c_q == C_OFF) ? 1'b0 : (stop_pend_q || ((c_q == C_ACTIVE) && ctrl_stop_i));

            if (enter_active || frame_done) f1_seen_q <= 1'b0;
            else if (cap_byte && hdr_q.f)   f1_seen_q <= 1'b1;

            if (enter_active)  sof_pend_q <= 1'b1;
            else if (cap_byte) sof_pend_q <= 1'b0;

            if (cap_byte) begin
                hold_vld_q <= 1'b1;
                hold_dat_q <= in_data_i;
                hold_sof_q <= sof_pend_q;
            end else if (ff_idle) begin
                hold_vld_q <= 1'b0;
            end

            wr_vld_q <= hold_vld_q && (cap_byte || ff_idle);
            wr_dat_q <= {hold_sof_q, ff_idle, hold_dat_q};

            if (eol_evt) begin
                line_len_q  <= line_cnt_q;
                line_cnt_q  <= '0;
                lines_acc_q <= lines_acc_q + 1'b1;
            end else if (cap_byte && (line_cnt_q != '1)) begin
                line_cnt_q  <= line_cnt_q + 1'b1;
            end

            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                lines_q     <= lines_acc_q;
                lines_acc_q <= '0;
            end

            err_hdr_q <= (err_hdr_q && !err_clr_i) || hdr_err;
            err_ovf_q <= (err_ovf_q && !err_clr_i) || (wr_vld_q && fifo_full);
        end
    end

    bt656_cap_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (ACLK),
        .rstn   (ARESETn),
        .wr_vld (wr_vld_q),
        .wr_dat (wr_dat_q),
        .full   (fifo_full),
        .rd     (out_if.master)
    );

    assign out_if.rdy         = out_ready_i;
    assign out_valid_o        = out_if.vld;
    assign out_data_o         = out_if.vld ? out_if.dat.dat : 8'h00;
    assign out_sof_o          = out_if.vld && out_if.dat.sof;
    assign out_eol_o          = out_if.vld && out_if.dat.eol;
    assign status_busy_o      = (c_q != C_OFF);
    assign status_frame_cnt_o = frame_cnt_q;
    assign status_line_len_o  = line_len_q;
    assign status_lines_o     = lines_q;
    assign err_hdr_o          = err_hdr_q;
    assign err_ovf_o          = err_ovf_q;
endmodule

// File: tb/tb_bt656_capture_ctrl.sv
// Drives a synthetic 32-line BT.656 source with random gaps/data and random backpressure,
// and compares the captured stream and status against a frame-level expectation queue.
module tb_bt656_capture_ctrl;
    import bt656_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        ctrl_start_i = 1'b0;
    logic        ctrl_stop_i = 1'b0;
    logic        ctrl_continuous_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [7:0]  out_data_o;
    logic        out_sof_o, out_eol_o, status_busy_o, err_hdr_o, err_ovf_o;
    logic [15:0] status_frame_cnt_o, status_line_len_o, status_lines_o;

    always #5 ACLK = ~ACLK;

    bt656_capture_ctrl_if mon_if ();
    assign mon_if.vld = out_valid_o;
    assign mon_if.rdy = out_ready_i;
    assign mon_if.dat = {out_sof_o, out_eol_o, out_data_o};

    bt656_capture_ctrl #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
        .ACLK               (ACLK),
        .ARESETn            (ARESETn),
        .in_valid_i         (in_valid_i),
        .in_data_i          (in_data_i),
        .ctrl_start_i       (ctrl_start_i),
        .ctrl_stop_i        (ctrl_stop_i),
        .ctrl_continuous_i  (ctrl_continuous_i),
        .err_clr_i          (err_clr_i),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_data_o         (out_data_o),
        .out_sof_o          (out_sof_o),
        .out_eol_o          (out_eol_o),
        .status_busy_o      (status_busy_o),
        .status_frame_cnt_o (status_frame_cnt_o),
        .status_line_len_o  (status_line_len_o),
        .status_lines_o     (status_lines_o),
        .err_hdr_o          (err_hdr_o),
        .err_ovf_o          (err_ovf_o)
    );

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eol;
    } beat_t;

    beat_t       rx[$];
    beat_t       ex[$];
    int          errors = 0;
    int          checks = 0;
    int          stab_viol = 0;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_out = '0;
    bit          stall = 1'b0;
    bit          nogap = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: record accepted beats and watch that a stalled beat never changes.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && ({out_valid_o, out_sof_o, out_eol_o, out_data_o} != prev_out))
                stab_viol <= stab_viol + 1;
            if (out_valid_o && out_ready_i)
                rx.push_back('{d: out_data_o, sof: out_sof_o, eol: out_eol_o});
            prev_stall <= out_valid_o && !out_ready_i;
            prev_out   <= {out_valid_o, out_sof_o, out_eol_o, out_data_o};
        end
    end

    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            out_ready_i = stall ? 1'b0 : ($urandom_range(0, 15) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (!nogap && ($urandom_range(0, 3) == 0)) begin
            in_valid_i = 1'b0;
            tick();
        end
        in_valid_i = 1'b1;
        in_data_i  = b;
        tick();
        in_valid_i = 1'b0;
    endtask

    function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    task automatic send_hdr(input logic f, input logic v, input logic h, input bit bad);
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(xy(f, v, h) ^ {7'd0, bad});
    endtask

    task automatic pulse_start(); ctrl_start_i = 1'b1; tick(); ctrl_start_i = 1'b0; endtask
    task automatic pulse_stop();  ctrl_stop_i  = 1'b1; tick(); ctrl_stop_i  = 1'b0; endtask
    task automatic pulse_clr();   err_clr_i    = 1'b1; tick(); err_clr_i    = 1'b0; endtask

    task automatic do_reset();
        #2;
        ARESETn = 1'b0;
        #1;
        check("rst_valid", out_valid_o, 0);
        check("rst_busy", status_busy_o, 0);
        check("rst_frame_cnt", status_frame_cnt_o, 0);
        check("rst_err_ovf", err_ovf_o, 0);
        check("rst_lines", status_lines_o, 0);
        in_valid_i = 1'b0;
        stall = 1'b0;
        nogap = 1'b0;
        tick();
        tick();
        ARESETn = 1'b1;
        tick();
    endtask

    // Lines 0-4 F0 V1, 5-12 field-0 active, 13-15 F1 V1, 16-23 field-1 active, 24-31 F1 V1.
    task automatic send_frame(input bit cap, input int bad_line = -1, input int stop_line = -1,
                              input int start_line = -1, input int stall_line = -1,
                              input int rst_line = -1);
        bit first;
        first = 1'b1;
        for (int l = 0; l < 32; l++) begin
            bit f, v;
            f = (l >= 13);
            v = !((l >= 5 && l < 13) || (l >= 16 && l < 24));
            if (l == start_line) pulse_start();
            if (l == stop_line) pulse_stop();
            send_hdr(f, v, 1'b0, l == bad_line);
            for (int i = 0; i < 48; i++) begin
                logic [7:0] b;
                b = (i == 0) ? {l[3:0], 4'h0} : 8'($urandom_range(1, 254));
                if (l == rst_line && i == 20) begin
                    do_reset();
                    return;
                end
                if (l == stall_line && i == 8) begin
                    stall = 1'b1;
                    nogap = 1'b1;
                end
                send_byte(b);
                if (cap && !v && l != bad_line) begin
                    ex.push_back('{d: b, sof: first, eol: (i == 47)});
                    first = 1'b0;
                end
            end
            stall = 1'b0;
            nogap = 1'b0;
            send_hdr(f, v, 1'b1, 1'b0);
            repeat (2) begin
                send_byte(8'h80);
                send_byte(8'h10);
            end
        end
    endtask

    task automatic drain();
        int idle = 0;
        int n = 0;
        while (idle < 20 && n < 3000) begin
            tick();
            n++;
            idle = out_valid_o ? 0 : idle + 1;
        end
        check("drain", idle >= 20, 1);
    endtask

    task automatic cmp_stream(input int base, input string tag);
        int bad = -1;
        int n = rx.size() - base;
        check({tag, "_len"}, n, ex.size());
        for (int i = 0; i < n && i < ex.size(); i++)
            if (bad < 0 && (rx[base+i].d !== ex[i].d || rx[base+i].sof !== ex[i].sof ||
                            rx[base+i].eol !== ex[i].eol))
                bad = i;
        check({tag, "_first_bad"}, bad, -1);
    endtask

    function automatic int count_flags(input int base, input bit want_sof);
        int c = 0;
        for (int i = base; i < rx.size(); i++)
            if (want_sof ? rx[i].sof : rx[i].eol) c++;
        return c;
    endfunction

    initial begin
        int base;
        int bad;
        int n;

        tick();
        tick();
        check("reset_valid", out_valid_o, 0);
        check("reset_busy", status_busy_o, 0);
        check("reset_frame_cnt", status_frame_cnt_o, 0);
        check("reset_err_hdr", err_hdr_o, 0);
        check("reset_data", out_data_o, 0);
        ARESETn = 1'b1;
        tick();

        // Single frame.
        base = rx.size();
        ex.delete();
        pulse_start();
        check("s1_busy_armed", status_busy_o, 1);
        send_frame(1'b1);
        check("s1_busy_done", status_busy_o, 0);
        send_frame(1'b0);
        drain();
        cmp_stream(base, "s1");
        check("s1_eol_cnt", count_flags(base, 1'b0), 16);
        check("s1_sof_cnt", count_flags(base, 1'b1), 1);
        check("s1_frame_cnt", status_frame_cnt_o, 1);
        check("s1_lines", status_lines_o, 16);
        check("s1_line_len", status_line_len_o, 48);
        check("s1_err_hdr", err_hdr_o, 0);
        check("s1_err_ovf", err_ovf_o, 0);

        // Continuous, stop requested mid-frame 3.
        base = rx.size();
        ex.delete();
        ctrl_continuous_i = 1'b1;
        pulse_start();
        send_frame(1'b1);
        send_frame(1'b1);
        send_frame(1'b1, -1, 8);
        check("s2_busy_after_stop", status_busy_o, 0);
        send_frame(1'b0);
        drain();
        cmp_stream(base, "s2");
        check("s2_sof_cnt", count_flags(base, 1'b1), 3);
        check("s2_frame_cnt", status_frame_cnt_o, 4);

        // Start mid-field 1: capture begins at next frame's first field-0 line.
        base = rx.size();
        ex.delete();
        ctrl_continuous_i = 1'b0;
        send_frame(1'b0, -1, -1, 18);
        check("s3_armed", status_busy_o, 1);
        check("s3_no_early_out", rx.size() - base, 0);
        send_frame(1'b1);
        drain();
        cmp_stream(base, "s3");
        if (rx.size() > base) begin
            check("s3_first_byte", rx[base].d, 8'h50);
            check("s3_first_sof", rx[base].sof, 1);
        end else begin
            check("s3_first_present", rx.size() - base, 1);
        end
        check("s3_frame_cnt", status_frame_cnt_o, 5);

        // Corrupted SAV protection bit drops that line.
        base = rx.size();
        ex.delete();
        pulse_start();
        send_frame(1'b1, 8);
        drain();
        cmp_stream(base, "s4");
        check("s4_err_hdr", err_hdr_o, 1);
        check("s4_lines", status_lines_o, 15);
        pulse_clr();
        check("s4_err_hdr_clr", err_hdr_o, 0);
        check("s4_frame_cnt", status_frame_cnt_o, 6);

        // Long stall on a field-0 line forces overflow; field 1 must arrive intact.
        base = rx.size();
        ex.delete();
        pulse_start();
        send_frame(1'b1, -1, -1, -1, 10);
        drain();
        check("s5_err_ovf", err_ovf_o, 1);
        check("s5_stable", stab_viol, 0);
        check("s5_lines", status_lines_o, 16);
        check("s5_line_len", status_line_len_o, 48);
        check("s5_frame_cnt", status_frame_cnt_o, 7);
        n = rx.size() - base;
        check("s5_dropped", n < ex.size(), 1);
        if (n >= 384) begin
            bad = -1;
            for (int i = 0; i < 384; i++) begin
                beat_t r, e;
                r = rx[rx.size() - 384 + i];
                e = ex[ex.size() - 384 + i];
                if (bad < 0 && (r.d !== e.d || r.sof !== e.sof || r.eol !== e.eol)) bad = i;
            end
            check("s5_tail_first_bad", bad, -1);
            check("s5_sof", rx[base].sof, 1);
        end else begin
            check("s5_tail_len", n >= 384, 1);
        end

        // Async reset mid-line, then a clean capture.
        ex.delete();
        pulse_start();
        send_frame(1'b1, -1, -1, -1, -1, 8);
        check("s6_busy_post_rst", status_busy_o, 0);
        check("s6_err_ovf_post_rst", err_ovf_o, 0);
        ex.delete();
        base = rx.size();
        pulse_start();
        send_frame(1'b1);
        drain();
        cmp_stream(base, "s6");
        check("s6_frame_cnt", status_frame_cnt_o, 1);
        check("s6_lines", status_lines_o, 16);
        check("s6_stable", stab_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
